// File: rtl/instruction_fetch.sv
// Instruction fetch stage for the RV64I single-cycle core.
// Holds the PC, fetches one 32-bit instruction per step over a req/ack
// handshake, presents it to decode and advances the PC on retirement.
//
// Handshake (imem_req / imem_ack): imem_req is driven from registered state
// only. A transfer completes on a rising edge where imem_req and imem_ack are
// both 1; imem_rdata is captured on that edge and imem_req drops on the next
// cycle. imem_ack seen while imem_req is 0 is stale and is discarded.
module instruction_fetch #(
  parameter int unsigned      XLEN         = 64,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 64'h0000_0000_0040_0000,
  parameter logic [31:0]      NOP_INST     = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write_enable,
  input  logic            branch_enable,
  input  logic            branch_taken,
  input  logic [1:0]      next_pc_sel,
  input  logic [XLEN-1:0] target_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [6:0]      inst_opcode,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned_exc,
  output logic [XLEN-1:0] retired_count,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] CNT_STEP = {{(XLEN-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;
  logic              req_en_q;   // low for the one cycle after any reset edge
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   count_q;
  logic [31:0]       inst_q;
  logic [XLEN-1:0]   seq_pc;
  logic [XLEN-1:0]   next_pc;
  logic              take_target;
  logic              fetch_done;
  logic              retire;
  logic              retire_ok;
  logic              retire_trap;

  assign seq_pc = pc_q + PC_STEP;

  // Next-PC selection and retirement qualifiers.
  always_comb begin
    take_target = 1'b0;
    next_pc     = seq_pc;
    if (next_pc_sel == 2'b10) begin
      take_target = 1'b1;
    end else if (next_pc_sel == 2'b01 && branch_enable && branch_taken) begin
      take_target = 1'b1;
    end
    if (take_target) begin
      next_pc = target_addr;
    end
  end

  assign fetch_done  = (state_q == S_FETCH) && req_en_q && imem_ack;
  assign retire      = (state_q == S_EXEC) && pc_write_enable;
  assign retire_ok   = retire && (next_pc[1:0] == 2'b00);
  assign retire_trap = retire && (next_pc[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; TRAP is left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (fetch_done) state_d = S_EXEC;
      S_EXEC: begin
        if (retire_ok)        state_d = S_FETCH;
        else if (retire_trap) state_d = S_TRAP;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // PC, held instruction, retirement counter and request enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_VECTOR;
      inst_q   <= NOP_INST;
      count_q  <= '0;
      req_en_q <= 1'b0;
    end else begin
      req_en_q <= 1'b1;
      if (fetch_done) begin
        inst_q <= imem_rdata;
      end
      if (retire_ok) begin
        pc_q    <= next_pc;
        count_q <= count_q + CNT_STEP;
        inst_q  <= NOP_INST;
      end
      if (retire_trap) begin
        inst_q <= NOP_INST;
      end
    end
  end

  assign imem_req       = (state_q == S_FETCH) && req_en_q;
  assign imem_addr      = pc_q;
  assign inst           = inst_q;
  assign inst_opcode    = inst_q[6:0];
  assign inst_valid     = (state_q == S_EXEC);
  assign pc             = pc_q;
  assign pc_plus4       = seq_pc;
  assign misaligned_exc = (state_q == S_TRAP);
  assign retired_count  = count_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table,
// hand-written corner sequences and randomized cycles against a reference model.
module tb_instruction_fetch;

  localparam logic [63:0] RV  = 64'h0000_0000_0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        pc_write_enable, branch_enable, branch_taken;
  logic [1:0]  next_pc_sel;
  logic [63:0] target_addr;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [6:0]  inst_opcode;
  logic        inst_valid;
  logic [63:0] pc, pc_plus4, retired_count;
  logic        misaligned_exc;
  logic [1:0]  fsm_state;

  instruction_fetch dut (
    .clk(clk), .rst(rst),
    .pc_write_enable(pc_write_enable), .branch_enable(branch_enable),
    .branch_taken(branch_taken), .next_pc_sel(next_pc_sel),
    .target_addr(target_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
    .inst_opcode(inst_opcode), .inst_valid(inst_valid), .pc(pc),
    .pc_plus4(pc_plus4), .misaligned_exc(misaligned_exc),
    .retired_count(retired_count), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Abstract view: an instruction is either held or being fetched; the core
  // is either running or trapped; requests are suppressed for one cycle
  // after a reset edge.
  logic [63:0] m_pc, m_cnt;
  logic [31:0] m_inst;
  logic        m_have, m_trap, m_req_ok;

  task automatic model_step();
    logic [63:0] nxt;
    if (rst) begin
      m_pc = RV; m_cnt = 0; m_inst = NOP;
      m_have = 0; m_trap = 0; m_req_ok = 0;
    end else begin
      if (!m_trap) begin
        if (!m_have) begin
          if (m_req_ok && imem_ack) begin
            m_inst = imem_rdata;
            m_have = 1;
          end
        end else if (pc_write_enable) begin
          if (next_pc_sel == 2'b10 ||
              (next_pc_sel == 2'b01 && branch_enable && branch_taken))
            nxt = target_addr;
          else
            nxt = m_pc + 64'd4;
          m_have = 0;
          m_inst = NOP;
          if (nxt % 64'd4 == 0) begin
            m_pc  = nxt;
            m_cnt = m_cnt + 64'd1;
          end else begin
            m_trap = 1;
          end
        end
      end
      m_req_ok = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic pwe, input logic be,
                       input logic bt, input logic [1:0] sel,
                       input logic [63:0] tgt, input logic ack,
                       input logic [31:0] rdata);
    rst = r; pc_write_enable = pwe; branch_enable = be; branch_taken = bt;
    next_pc_sel = sel; target_addr = tgt; imem_ack = ack; imem_rdata = rdata;
  endtask

  // Advance one clock: the model consumes the same inputs the DUT sees at
  // the edge; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " req"},   {63'd0, imem_req},   {63'd0, !m_trap && !m_have && m_req_ok});
    check({tag, " valid"}, {63'd0, inst_valid}, {63'd0, m_have});
    check({tag, " pc"},    pc,        m_pc);
    check({tag, " addr"},  imem_addr, m_pc);
    check({tag, " pc4"},   pc_plus4,  m_pc + 64'd4);
    check({tag, " cnt"},   retired_count, m_cnt);
    check({tag, " inst"},  {32'd0, inst}, {32'd0, m_inst});
    check({tag, " opc"},   {57'd0, inst_opcode}, {57'd0, m_inst[6:0]});
    check({tag, " exc"},   {63'd0, misaligned_exc}, {63'd0, m_trap});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, pwe, be, bt;
    logic [1:0]  sel;
    logic [63:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_valid;
    logic [63:0] e_pc, e_cnt;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic pwe, input logic be,
                              input logic bt, input logic [1:0] sel,
                              input logic [63:0] tgt, input logic ack,
                              input logic [31:0] rdata, input logic e_req,
                              input logic e_valid, input logic [63:0] e_pc,
                              input logic [63:0] e_cnt, input logic [31:0] e_inst);
    vec_t v;
    v.rst = r; v.pwe = pwe; v.be = be; v.bt = bt; v.sel = sel; v.tgt = tgt;
    v.ack = ack; v.rdata = rdata; v.e_req = e_req; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_inst = e_inst;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    logic [63:0] tgt;
    drive(1, 0, 0, 0, 2'b00, 64'd0, 0, 32'd0);

    // Each row: inputs applied for one edge, expected outputs after it.
    vecs[0]  = mk(1,0,0,0,2'b00,64'd0,0,32'd0,             0,0,RV,0,NOP);
    vecs[1]  = mk(1,0,0,0,2'b00,64'd0,0,32'd0,             0,0,RV,0,NOP);
    vecs[2]  = mk(1,0,0,0,2'b00,64'd0,0,32'd0,             0,0,RV,0,NOP);
    vecs[3]  = mk(0,0,0,0,2'b00,64'd0,0,32'd0,             1,0,RV,0,NOP);
    vecs[4]  = mk(0,0,0,0,2'b00,64'd0,0,32'd0,             1,0,RV,0,NOP);
    vecs[5]  = mk(0,0,0,0,2'b00,64'd0,0,32'd0,             1,0,RV,0,NOP);
    vecs[6]  = mk(0,0,0,0,2'b00,64'd0,1,32'h00500093,      0,1,RV,0,32'h00500093);
    vecs[7]  = mk(0,1,0,0,2'b00,64'd0,0,32'd0,             1,0,RV+64'd4,1,NOP);
    vecs[8]  = mk(0,0,0,0,2'b00,64'd0,1,32'h06300063,      0,1,RV+64'd4,1,32'h06300063);
    vecs[9]  = mk(0,1,1,1,2'b01,64'h400100,0,32'd0,        1,0,64'h400100,2,NOP);
    vecs[10] = mk(0,0,0,0,2'b00,64'd0,1,32'h06300063,      0,1,64'h400100,2,32'h06300063);
    vecs[11] = mk(0,1,1,0,2'b01,64'h400100,0,32'd0,        1,0,64'h400104,3,NOP);
    vecs[12] = mk(0,0,0,0,2'b00,64'd0,1,32'h0000006f,      0,1,64'h400104,3,32'h0000006f);
    vecs[13] = mk(0,1,0,0,2'b11,64'h400200,0,32'd0,        1,0,64'h400108,4,NOP);
    vecs[14] = mk(0,1,0,0,2'b10,64'h400200,1,32'h0080006f, 0,1,64'h400108,4,32'h0080006f);
    vecs[15] = mk(0,0,0,0,2'b10,64'h400200,1,32'hffffffff, 0,1,64'h400108,4,32'h0080006f);
    vecs[16] = mk(0,1,0,0,2'b10,64'h400200,0,32'd0,        1,0,64'h400200,5,NOP);
    vecs[17] = mk(0,0,0,0,2'b00,64'd0,1,32'h00208463,      0,1,64'h400200,5,32'h00208463);
    vecs[18] = mk(0,1,0,1,2'b01,64'h400300,0,32'd0,        1,0,64'h400204,6,NOP);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].pwe, vecs[i].be, vecs[i].bt, vecs[i].sel,
            vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
      tick();
      check($sformatf("vec%0d req", i),   {63'd0, imem_req},   {63'd0, vecs[i].e_req});
      check($sformatf("vec%0d valid", i), {63'd0, inst_valid}, {63'd0, vecs[i].e_valid});
      check($sformatf("vec%0d pc", i),    pc,            vecs[i].e_pc);
      check($sformatf("vec%0d addr", i),  imem_addr,     vecs[i].e_pc);
      check($sformatf("vec%0d pc4", i),   pc_plus4,      vecs[i].e_pc + 64'd4);
      check($sformatf("vec%0d cnt", i),   retired_count, vecs[i].e_cnt);
      check($sformatf("vec%0d inst", i),  {32'd0, inst}, {32'd0, vecs[i].e_inst});
      check($sformatf("vec%0d opc", i),   {57'd0, inst_opcode}, {57'd0, vecs[i].e_inst[6:0]});
      check($sformatf("vec%0d exc", i),   {63'd0, misaligned_exc}, 64'd0);
    end

    // ---- misaligned jump: trap is sticky for 10 cycles, reset clears it ----
    drive(0, 0, 0, 0, 2'b00, 64'd0, 1, 32'h0000006f);
    tick();
    check_model("trap_fetch");
    drive(0, 1, 0, 0, 2'b10, 64'h400102, 0, 32'd0);
    tick();
    check("trap exc",   {63'd0, misaligned_exc}, 64'd1);
    check("trap pc",    pc, 64'h400204);
    check("trap cnt",   retired_count, 64'd6);
    check_model("trap_enter");
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 1, 2'($urandom_range(0, 3)), {$urandom, $urandom} & ~64'd3,
            1, $urandom);
      tick();
      check($sformatf("trap%0d req", i), {63'd0, imem_req}, 64'd0);
      check($sformatf("trap%0d pc", i),  pc, 64'h400204);
      check($sformatf("trap%0d cnt", i), retired_count, 64'd6);
      check($sformatf("trap%0d exc", i), {63'd0, misaligned_exc}, 64'd1);
    end
    drive(1, 0, 0, 0, 2'b00, 64'd0, 0, 32'd0);
    tick();
    check("trap_clr exc", {63'd0, misaligned_exc}, 64'd0);
    check_model("trap_clr");
    drive(0, 0, 0, 0, 2'b00, 64'd0, 0, 32'd0);
    tick();
    check("post_trap req", {63'd0, imem_req}, 64'd1);

    // ---- reset mid-fetch, stale ack right after release is discarded ----
    drive(1, 0, 0, 0, 2'b00, 64'd0, 0, 32'd0);
    tick();
    check("midrst req", {63'd0, imem_req}, 64'd0);
    drive(0, 0, 0, 0, 2'b00, 64'd0, 1, 32'hdeadbeef);
    tick();
    check("stale valid", {63'd0, inst_valid}, 64'd0);
    check("stale pc", pc, RV);
    check_model("stale");
    drive(0, 0, 0, 0, 2'b00, 64'd0, 1, 32'h00000013);
    tick();
    check_model("refetch");

    // ---- wrap: jump to top of address space, then sequential step ----
    drive(0, 1, 0, 0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'd0);
    tick();
    check("wrap top pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, 0, 0, 0, 2'b00, 64'd0, 1, 32'h00000093);
    tick();
    check_model("wrap_fetch");
    drive(0, 1, 0, 0, 2'b00, 64'd0, 0, 32'd0);
    tick();
    check("wrap pc", pc, 64'd0);
    check("wrap pc4", pc_plus4, 64'd4);
    check_model("wrap");

    // ---- randomized cycles against the model ----
    for (int i = 0; i < 600; i++) begin
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), tgt, $urandom_range(0, 1) == 1, $urandom);
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the RV64I single-cycle core, directly upstream of the single-cycle control decoder. Holds the program counter and fetches one 32-bit instruction per step from instruction memory over a request/acknowledge handshake. Presents the instruction, its opcode field and its PC to decode/execute. Advances the PC when the core asserts `pc_write_enable`, choosing sequential, branch or jump targets, and traps on a misaligned next PC.

## Interface
- `XLEN`, 64: PC and address width.
- `RESET_VECTOR`, 64'h0000_0000_0040_0000: PC value after reset.
- `NOP_INST`, 32'h0000_0013: instruction presented while no valid instruction is held (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `pc_write_enable` in 1: from control; retires the held instruction.
- `branch_enable` in 1: from control; the instruction is a conditional branch.
- `branch_taken` in 1: branch comparator result.
- `next_pc_sel` in 2: 00 = sequential; 01 = branch; 10 = jump (JAL/JALR); 11 = reserved, treated as 00.
- `target_addr` in XLEN: computed branch/jump target. JALR bit 0 is already cleared upstream.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: fetch address; equals `pc`.
- `imem_ack` in 1: memory has returned data this cycle.
- `imem_rdata` in 32: instruction word, valid when `imem_ack`=1.
- `inst` out 32: held instruction, or `NOP_INST` when invalid.
- `inst_opcode` out 7: `inst[6:0]`.
- `inst_valid` out 1: `inst` is valid and awaiting retirement.
- `pc` out XLEN: PC of the current instruction.
- `pc_plus4` out XLEN: `pc + 4`, modulo 2^XLEN (link value for JAL/JALR).
- `misaligned_exc` out 1: sticky instruction-address-misaligned trap.
- `retired_count` out XLEN: count of retired instructions.

## Operation
The block is an FSM with three states: FETCH, EXEC, TRAP.

- **Reset** forces the following, with the state going to FETCH:
  - `pc`=`RESET_VECTOR`, `inst`=`NOP_INST`, `inst_valid`=0.
  - `misaligned_exc`=0, `retired_count`=0.
  - `imem_req`=0 in the reset cycle.
- **FETCH**:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On an edge with `imem_ack`=1: capture `imem_rdata` into `inst` and go to EXEC.
  - `pc_write_enable` is ignored in FETCH.
- **EXEC**:
  - `inst_valid`=1 and `imem_req`=0. `inst` and `pc` are stable.
  - On an edge with `pc_write_enable`=1, compute `next_pc`:
    - sel 10 → `target_addr`.
    - sel 01 with `branch_enable` & `branch_taken` → `target_addr`.
    - otherwise → `pc + 4`.
  - If `next_pc[1:0]` == 0: `pc` <= `next_pc`, `retired_count` += 1 (wraps), `inst` <= `NOP_INST`, and the state goes to FETCH.
  - If `next_pc[1:0]` != 0: `pc` is unchanged, `retired_count` is unchanged, and the state goes to TRAP.
- **TRAP**:
  - `misaligned_exc`=1, `imem_req`=0, `inst_valid`=0.
  - Only `rst` exits this state.
- `imem_ack` is ignored whenever `imem_req`=0 (stale or late acknowledges are discarded).
- All PC arithmetic is unsigned modulo 2^XLEN; `pc + 4` from 0xFFFF_FFFF_FFFF_FFFC is 0.
- Downstream must gate the regfile and data-memory write enables with `inst_valid`. `NOP_INST` makes the decode of invalid cycles harmless.

## Timing
- All outputs are registered or derived only from registered state. There is no combinational path from `imem_rdata` or `imem_ack` to any output.
- Fetch latency: with `imem_ack` in the first FETCH cycle, `inst_valid`=1 on the next cycle. Each cycle of ack delay adds one cycle.
- Minimum throughput is 2 cycles per instruction (FETCH + EXEC).
- The PC update is visible the cycle after the retiring edge. `imem_addr` presents the new PC in that same cycle.
- `rst` overrides everything on any edge, including mid-FETCH with an outstanding request. `imem_req` is 0 on the following cycle, and instruction memory must tolerate the abandoned request.
- Simultaneous `rst` and `pc_write_enable`: reset wins and there is no retirement.

## Test plan
- **Reset:** hold `rst` 3 cycles → `pc`=0x400000, `imem_req`=0, `inst_valid`=0, `inst`=0x00000013. First cycle after release → `imem_req`=1, `imem_addr`=0x400000.
- **Delayed ack, sequential step:** ack 2 cycles after the request with `imem_rdata`=0x00500093 → `inst_valid`=1 the next cycle and `inst_opcode`=0x13. Retire with sel 00 → `imem_addr`=0x400004 and `retired_count`=1.
- **Branch:** sel 01, `branch_enable`=1, `target_addr`=0x400100.
  - `branch_taken`=1 → next fetch at 0x400100.
  - Repeat with `branch_taken`=0 → next fetch at `pc`+4.
- **Misaligned jump:** sel 10, `target_addr`=0x400102 → TRAP, `misaligned_exc`=1. `imem_req` stays 0 and `pc`/`retired_count` are unchanged over 10 cycles. `rst` then clears it.
- **Reset mid-fetch:** assert `rst` while `imem_req`=1 and no ack, then ack 1 cycle after release at a stale address → the ack is discarded if `imem_req` was 0 that cycle. `pc`=0x400000.
- **Wrap:** `pc`=0xFFFF_FFFF_FFFF_FFFC, retire with sel 00 → `pc`=0, `pc_plus4` of the new instruction = 4.
